// File: rtl/ppgen_pkg.sv
// Shared types and helpers for the sequential 16x16 partial-product generator.
// Build option: PPGEN_ZERO_SKIP_EN enables skipping of zero partial products.
package ppgen_pkg;

  localparam int DW = 16;
  localparam int HW = DW / 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P_LL = 3'd1,
    P_LH = 3'd2,
    P_HL = 3'd3,
    P_HH = 3'd4,
    DONE = 3'd5
  } state_t;

  // Bit 1 picks the high byte of a, bit 0 picks the high byte of b.
  typedef enum logic [1:0] {
    SEL_LL = 2'b00,
    SEL_LH = 2'b01,
    SEL_HL = 2'b10,
    SEL_HH = 2'b11
  } sel_t;

  function automatic sel_t state_sel(input state_t s);
    case (s)
      P_LL:    return SEL_LL;
      P_LH:    return SEL_LH;
      P_HL:    return SEL_HL;
      P_HH:    return SEL_HH;
      default: return SEL_LL;
    endcase
  endfunction

  // One bit per product (LL, LH, HL, HH from bit 0): set when both bytes are nonzero.
  function automatic logic [3:0] nonzero_mask(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic xl, xh, yl, yh;
    xl = (x[HW-1:0]  != {HW{1'b0}});
    xh = (x[DW-1:HW] != {HW{1'b0}});
    yl = (y[HW-1:0]  != {HW{1'b0}});
    yh = (y[DW-1:HW] != {HW{1'b0}});
    return {xh & yh, xh & yl, xl & yh, xl & yl};
  endfunction

  // First enabled product phase at or after position start (0..4), else DONE.
  function automatic state_t next_phase(input logic [3:0] mask, input logic [2:0] start);
    logic [3:0] rem;
    rem = mask & ~((4'b0001 << start) - 4'b0001);
    if (rem[0])      return P_LL;
    else if (rem[1]) return P_LH;
    else if (rem[2]) return P_HL;
    else if (rem[3]) return P_HH;
    else             return DONE;
  endfunction

endpackage

// File: rtl/ppgen_seq_16_mul8.sv
// Combinational 8x8 unsigned multiplier, exact or truncated-array approximate.
module mul8_unit
  import ppgen_pkg::*;
#(
  parameter bit MUL_EXACT = 1'b1
) (
  input  logic [HW-1:0]   x,
  input  logic [HW-1:0]   y,
  output logic [2*HW-1:0] p
);

  if (MUL_EXACT) begin : g_exact
    assign p = {{HW{1'b0}}, x} * {{HW{1'b0}}, y};
  end else begin : g_approx
    // Columns below bit 4 are dropped; the constant bias recentres the error.
    always_comb begin
      logic [2*HW-1:0] acc;
      acc = 16'h0008;
      for (int i = 0; i < HW; i++) begin
        if (y[i]) begin
          acc = acc + (({{HW{1'b0}}, x} << i) & 16'hFFF0);
        end else begin
          acc = acc;
        end
      end
      p = acc;
    end
  end

endmodule

// File: rtl/ppgen_seq_16.sv
// Sequential partial-product generator: one 8x8 multiplier reused over four phases.
// Build option: PPGEN_ZERO_SKIP_EN skips phases whose product is known to be zero.
module ppgen_seq_16 #(
  parameter int DW        = 16,
  parameter bit MUL_EXACT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] ll,
  output logic [DW-1:0] lh,
  output logic [DW-1:0] hl,
  output logic [DW-1:0] hh,
  output logic          busy
);

  import ppgen_pkg::*;

  state_t        state;
  state_t        next_state;
  logic [DW-1:0] a_r;
  logic [DW-1:0] b_r;
  logic          accept;
  logic [3:0]    acc_mask;
  logic [3:0]    run_mask;
  logic [1:0]    sel;
  logic [HW-1:0] mul_a;
  logic [HW-1:0] mul_b;
  logic [DW-1:0] prod;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

`ifdef PPGEN_ZERO_SKIP_EN
  logic [3:0] mask_r;

  assign acc_mask = nonzero_mask(a, b);
  assign run_mask = mask_r;

  // Remember which phases the accepted operation still has to visit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r <= 4'b0000;
    end else if (accept) begin
      mask_r <= acc_mask;
    end else begin
      mask_r <= mask_r;
    end
  end
`else
  assign acc_mask = 4'b1111;
  assign run_mask = 4'b1111;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; DONE is left only on the output handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = next_phase(acc_mask, 3'd0);
        end else begin
          next_state = IDLE;
        end
      end
      P_LL: next_state = next_phase(run_mask, 3'd1);
      P_LH: next_state = next_phase(run_mask, 3'd2);
      P_HL: next_state = next_phase(run_mask, 3'd3);
      P_HH: next_state = next_phase(run_mask, 3'd4);
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            next_state = next_phase(acc_mask, 3'd0);
          end else begin
            next_state = IDLE;
          end
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Byte multiplexer feeding the shared multiplier.
  always_comb begin
    sel   = state_sel(state);
    mul_a = sel[1] ? a_r[DW-1:HW] : a_r[HW-1:0];
    mul_b = sel[0] ? b_r[DW-1:HW] : b_r[HW-1:0];
  end

  mul8_unit #(
    .MUL_EXACT (MUL_EXACT)
  ) u_mul (
    .x (mul_a),
    .y (mul_b),
    .p (prod)
  );

  // Operand capture and per-phase product registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= {DW{1'b0}};
      b_r <= {DW{1'b0}};
      ll  <= {DW{1'b0}};
      lh  <= {DW{1'b0}};
      hl  <= {DW{1'b0}};
      hh  <= {DW{1'b0}};
    end else begin
      if (accept) begin
        a_r <= a;
        b_r <= b;
`ifdef PPGEN_ZERO_SKIP_EN
        if (!acc_mask[0]) ll <= {DW{1'b0}};
        if (!acc_mask[1]) lh <= {DW{1'b0}};
        if (!acc_mask[2]) hl <= {DW{1'b0}};
        if (!acc_mask[3]) hh <= {DW{1'b0}};
`endif
      end
      case (state)
        P_LL:    ll <= prod;
        P_LH:    lh <= prod;
        P_HL:    hl <= prod;
        P_HH:    hh <= prod;
        default: ;
      endcase
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= (next_state == DONE);
      busy      <= (next_state != IDLE);
    end
  end

endmodule
